// File: rtl/lfsr_mem_test_ctrl.sv
// Write-then-verify RAM test sequencer: drives an external address/data LFSR pair
// and a single-port RAM, then reports pass, error count and first failing address.
module lfsr_mem_test_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 1023,
    parameter int RST_CYC = 2,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              lfsr_rstn,
    output logic              lfsr_en_addr,
    output logic              lfsr_en_data,
    input  logic [ADDR_W-1:0] lfsr_addr,
    input  logic [DATA_W-1:0] lfsr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(RST_CYC + RD_LAT + 1) + 1;
    localparam logic [ADDR_W-1:0] OPS_LAST = ADDR_W'(NUM_OPS);
    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]  RST_END  = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0]  LAT_END  = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LRST   = 3'd1,
        S_HI     = 3'd2,
        S_LO     = 3'd3,
        S_ACC    = 3'd4,
        S_RDWAIT = 3'd5,
        S_CMP    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic                phase_rd_q, phase_rd_d;
    logic [ADDR_W-1:0]   op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0]    sub_cnt_q, sub_cnt_d;
    logic [DATA_W-1:0]   exp_data_q, exp_data_d;
    logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic                lfsr_rstn_q, lfsr_rstn_d;
    logic                lfsr_en_q, lfsr_en_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]   op_cnt_inc_s;
    logic                mismatch_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign op_cnt_inc_s = op_cnt_q + 1'b1;
    assign mismatch_s   = (mem_rdata != exp_data_q);

    // Next-state and next-output logic for the test sequencer
    always_comb begin
        state_d          = state_q;
        phase_rd_d       = phase_rd_q;
        op_cnt_d         = op_cnt_q;
        sub_cnt_d        = sub_cnt_q;
        exp_data_d       = exp_data_q;
        exp_addr_d       = exp_addr_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        lfsr_rstn_d      = lfsr_rstn_q;
        lfsr_en_d        = 1'b0;
        mem_en_d         = 1'b0;
        mem_we_d         = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;

        // Abort pre-empts every busy state; counters keep their values
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            lfsr_rstn_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    lfsr_rstn_d = 1'b1;
                    if (abort) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end else if (start) begin
                        state_d          = S_LRST;
                        busy_d           = 1'b1;
                        done_d           = 1'b0;
                        pass_d           = 1'b0;
                        err_count_d      = 16'h0000;
                        first_err_addr_d = '0;
                        phase_rd_d       = 1'b0;
                        sub_cnt_d        = '0;
                        lfsr_rstn_d      = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_LRST: begin
                    if (sub_cnt_q == RST_END) begin
                        state_d   = S_HI;
                        lfsr_en_d = 1'b1;
                        op_cnt_d  = '0;
                    end else begin
                        sub_cnt_d   = sub_cnt_q + 1'b1;
                        lfsr_rstn_d = (sub_cnt_q == RST_LAST);
                    end
                end
                S_HI: begin
                    state_d = S_LO;
                end
                S_LO: begin
                    state_d = S_ACC;
                end
                S_ACC: begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = lfsr_addr;
                    if (!phase_rd_q) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = lfsr_data;
                        op_cnt_d    = op_cnt_inc_s;
                        if (op_cnt_inc_s == OPS_LAST) begin
                            phase_rd_d  = 1'b1;
                            state_d     = S_LRST;
                            sub_cnt_d   = '0;
                            lfsr_rstn_d = 1'b0;
                        end else begin
                            state_d   = S_HI;
                            lfsr_en_d = 1'b1;
                        end
                    end else begin
                        exp_data_d = lfsr_data;
                        exp_addr_d = lfsr_addr;
                        sub_cnt_d  = '0;
                        state_d    = S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (sub_cnt_q == LAT_END) begin
                        state_d = S_CMP;
                    end else begin
                        sub_cnt_d = sub_cnt_q + 1'b1;
                    end
                end
                S_CMP: begin
                    op_cnt_d = op_cnt_inc_s;
                    if (mismatch_s) begin
                        err_count_d = sat_inc(err_count_q);
                        if (err_count_q == 16'h0000) begin
                            first_err_addr_d = exp_addr_q;
                        end else begin
                            first_err_addr_d = first_err_addr_q;
                        end
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (op_cnt_inc_s == OPS_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == 16'h0000);
                    end else begin
                        state_d   = S_HI;
                        lfsr_en_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    lfsr_rstn_d = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            phase_rd_q       <= 1'b0;
            op_cnt_q         <= '0;
            sub_cnt_q        <= '0;
            exp_data_q       <= '0;
            exp_addr_q       <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= 16'h0000;
            first_err_addr_q <= '0;
            lfsr_rstn_q      <= 1'b0;
            lfsr_en_q        <= 1'b0;
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            phase_rd_q       <= phase_rd_d;
            op_cnt_q         <= op_cnt_d;
            sub_cnt_q        <= sub_cnt_d;
            exp_data_q       <= exp_data_d;
            exp_addr_q       <= exp_addr_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            lfsr_rstn_q      <= lfsr_rstn_d;
            lfsr_en_q        <= lfsr_en_d;
            mem_en_q         <= mem_en_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign lfsr_rstn      = lfsr_rstn_q;
    assign lfsr_en_addr   = lfsr_en_q;
    assign lfsr_en_data   = lfsr_en_q;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_lfsr_mem_test_ctrl.sv
// Scoreboard bench for lfsr_mem_test_ctrl: LFSR pair and faultable RAM models around
// the DUT, a reference model predicting RAM traffic and final results per run.
`timescale 1ns/1ps
module tb_lfsr_mem_test_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int N  = 1023;
    localparam int RC = 2;
    localparam int RL = 1;
    localparam logic [AW-1:0] A_SEED = 10'h3FF;
    localparam logic [DW-1:0] D_SEED = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic busy, done, pass, lfsr_rstn, lfsr_en_addr, lfsr_en_data, mem_en, mem_we;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, lfsr_addr, mem_addr;
    logic [DW-1:0] lfsr_data, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lfsr_mem_test_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_OPS(N), .RST_CYC(RC), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .lfsr_rstn(lfsr_rstn),
        .lfsr_en_addr(lfsr_en_addr), .lfsr_en_data(lfsr_en_data),
        .lfsr_addr(lfsr_addr), .lfsr_data(lfsr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Galois LFSR steps: x^10+x^3+1 and x^32+x^22+x^2+x+1, seeded all-ones
    function automatic logic [AW-1:0] a_next(input logic [AW-1:0] s);
        return {s[AW-2:0], 1'b0} ^ (s[AW-1] ? 10'h009 : 10'h000);
    endfunction
    function automatic logic [DW-1:0] d_next(input logic [DW-1:0] s);
        return {s[DW-2:0], 1'b0} ^ (s[DW-1] ? 32'h0040_0007 : 32'h0000_0000);
    endfunction

    // External LFSR pair: capture on rising strobe, advance on falling strobe
    logic [AW-1:0] la_st, la_out;
    logic [DW-1:0] ld_st, ld_out;
    logic ea_prev, ed_prev;
    always @(posedge clk) begin
        if (!lfsr_rstn) begin
            la_st <= A_SEED; la_out <= A_SEED; ea_prev <= 1'b0;
            ld_st <= D_SEED; ld_out <= D_SEED; ed_prev <= 1'b0;
        end else begin
            ea_prev <= lfsr_en_addr;
            ed_prev <= lfsr_en_data;
            if (lfsr_en_addr && !ea_prev) la_out <= la_st;
            else if (!lfsr_en_addr && ea_prev) la_st <= a_next(la_st);
            if (lfsr_en_data && !ed_prev) ld_out <= ld_st;
            else if (!lfsr_en_data && ed_prev) ld_st <= d_next(ld_st);
        end
    end
    assign lfsr_addr = la_out;
    assign lfsr_data = ld_out;

    // RAM with read latency RL and a selectable read fault
    int            fault_mode;   // 0 ideal, 1 flip one bit at one address, 2 stuck-at-0
    logic [AW-1:0] fault_addr;
    logic [4:0]    fault_bit;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [RL];
    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] m;
        m = '0;
        m[fault_bit] = 1'b1;
        if (fault_mode == 1 && a == fault_addr) return d ^ m;
        else if (fault_mode == 2) return '0;
        else return d;
    endfunction
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) rd_pipe[0] <= faulty(mem_addr, ram[mem_addr]);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct packed { logic [15:0] err; logic [AW-1:0] first; logic pass; logic [31:0] cyc; } res_t;
    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    res_t          res_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int prot_viol = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: expected writes (n_wr of them) and, for a complete run, reads and result
    task automatic predict(input int n_wr, input bit full);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        wr_t w;
        res_t r;
        a = A_SEED; d = D_SEED;
        for (int i = 0; i < n_wr; i++) begin
            w.a = a; w.d = d;
            wr_q.push_back(w);
            a = a_next(a); d = d_next(d);
        end
        if (full) begin
            a = A_SEED;
            for (int i = 0; i < N; i++) begin
                rd_q.push_back(a);
                a = a_next(a);
            end
            r.err   = (fault_mode == 0) ? 16'd0 : (fault_mode == 1) ? 16'd1 : 16'(N);
            r.first = (fault_mode == 1) ? fault_addr : (fault_mode == 2) ? A_SEED : '0;
            r.pass  = (fault_mode == 0);
            r.cyc   = 32'((RC + 1) * 2 + 3 * N + (3 + RL + 1) * N);
            res_q.push_back(r);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents RAM traffic or done
    int   cyc = 0, busy_start = 0, n_written = 0, n_wr_run = 0;
    logic busy_prev = 1'b0, done_prev = 1'b0, en_prev = 1'b0;
    logic [(1<<AW)-1:0] written_bits;
    task automatic monitor();
        wr_t w;
        res_t r;
        logic [AW-1:0] ra;
        forever begin
            @(negedge clk);
            cyc++;
            if (lfsr_en_addr !== lfsr_en_data) prot_viol++;
            if (lfsr_en_addr === 1'b1 && lfsr_rstn !== 1'b1) prot_viol++;
            if (lfsr_en_addr === 1'b1 && en_prev === 1'b1) prot_viol++;
            en_prev = lfsr_en_addr;
            if (busy === 1'b1 && busy_prev !== 1'b1) begin
                busy_start = cyc; written_bits = '0; n_written = 0; n_wr_run = 0;
            end
            if (mem_en === 1'b1 && mem_we === 1'b1) begin
                check("write_expected", 64'(wr_q.size() > 0), 64'd1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(w.a));
                    check("wr_data", 64'(mem_wdata), 64'(w.d));
                end
                if (n_wr_run == 0) check("first_write", {mem_addr, mem_wdata}, {10'h3FF, 32'hFFFF_FFFF});
                if (n_wr_run == 1) check("second_write", {mem_addr, mem_wdata}, {10'h3F7, 32'hFFBF_FFF9});
                n_wr_run++;
                if (!written_bits[mem_addr]) n_written++;
                written_bits[mem_addr] = 1'b1;
            end
            if (mem_en === 1'b1 && mem_we === 1'b0) begin
                check("read_expected", 64'(rd_q.size() > 0), 64'd1);
                if (rd_q.size() > 0) begin
                    ra = rd_q.pop_front();
                    check("rd_addr", 64'(mem_addr), 64'(ra));
                end
            end
            if (done === 1'b1 && done_prev !== 1'b1) begin
                check("done_expected", 64'(res_q.size() > 0), 64'd1);
                if (res_q.size() > 0) begin
                    r = res_q.pop_front();
                    check("err_count", 64'(err_count), 64'(r.err));
                    check("first_err_addr", 64'(first_err_addr), 64'(r.first));
                    check("pass", 64'(pass), 64'(r.pass));
                    check("test_cycles", 64'(cyc - busy_start), 64'(r.cyc));
                    check("distinct_wr_addrs", 64'(n_written), 64'(N));
                    check("addr0_unwritten", 64'(written_bits[0]), 64'd0);
                end
            end
            busy_prev = busy;
            done_prev = done;
        end
    endtask

    task automatic pulse_start();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run a complete test, optionally poking start while busy, and wait for done
    task automatic run_full(input int mode, input logic [AW-1:0] fa, input logic [4:0] fb, input bit poke);
        bit got_done;
        fault_mode = mode; fault_addr = fa; fault_bit = fb;
        predict(N, 1'b1);
        pulse_start();
        got_done = 1'b0;
        for (int k = 0; k < 9000 && !got_done; k++) begin
            @(negedge clk);
            start = (poke && busy === 1'b1 && $urandom_range(0, 299) == 0);
            got_done = (done === 1'b1);
        end
        start = 1'b0;
        check("done_within_budget", 64'(got_done), 64'd1);
        check("busy_low_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("writes_drained", 64'(wr_q.size()), 64'd0);
        check("reads_drained", 64'(rd_q.size()), 64'd0);
        check("lfsr_protocol", 64'(prot_viol), 64'd0);
    endtask

    task automatic wait_strobe(input int nth);
        int seen;
        bit ok;
        seen = 0; ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (lfsr_en_addr === 1'b1) begin
                seen++;
                ok = (seen == nth);
            end
        end
        check("strobe_reached", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_state();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_first_err_addr", 64'(first_err_addr), 64'd0);
        check("rst_lfsr_rstn", 64'(lfsr_rstn), 64'd0);
        check("rst_strobes", 64'({lfsr_en_addr, lfsr_en_data}), 64'd0);
        check("rst_mem_ctl", 64'({mem_en, mem_we}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        fault_mode = 0; fault_addr = '0; fault_bit = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);
        check("idle_lfsr_rstn", 64'(lfsr_rstn), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // Clean run on an ideal RAM
        run_full(0, '0, '0, 1'b0);

        // Bit 0 flipped on reads of 0x3F7
        run_full(1, 10'h3F7, 5'd0, 1'b0);

        // start and abort together in DONE: abort wins, back to IDLE with done low
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_done", 64'(done), 64'd0);
        @(negedge clk);
        check("start_abort_stays_idle", 64'({busy, mem_en, lfsr_en_addr}), 64'd0);

        // Random single-bit fault at a random nonzero address
        run_full(1, AW'($urandom_range(1, (1 << AW) - 1)), 5'($urandom_range(0, DW - 1)), 1'b0);

        // Abort during the 5th S_HI: four writes happen, then everything idles
        fault_mode = 0;
        predict(4, 1'b0);
        pulse_start();
        wait_strobe(5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_mem_en", 64'(mem_en), 64'd0);
        check("abort_strobes", 64'({lfsr_en_addr, lfsr_en_data}), 64'd0);
        check("abort_err_hold", 64'(err_count), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_writes", 64'(wr_q.size()), 64'd0);
        run_full(0, '0, '0, 1'b0);

        // rst during the 3rd write-phase ACC: only two writes land
        predict(2, 1'b0);
        pulse_start();
        wait_strobe(3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_quiet", 64'({mem_en, lfsr_rstn, lfsr_en_addr}), 64'd0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_writes", 64'(wr_q.size()), 64'd0);
        check("rst_idle_busy", 64'(busy), 64'd0);

        // Stuck-at-0 RAM with start pulsed while busy
        run_full(2, '0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_mem_test_ctrl.md
Name: lfsr_mem_test_ctrl

Overview:
- Sequencer for the LFSR pattern generator (10-bit address LFSR, 32-bit data LFSR) and a single-port block RAM.
- Runs a write-then-verify memory test:
  - Resets the LFSR pair and strobes it NUM_OPS times, writing each (address, data) pair to RAM.
  - Resets the LFSR pair again and replays the identical sequence, reading RAM and comparing.
- Reports pass/fail, error count and first failing address to the PS-side register block.

Parameters:
- ADDR_W, 10, RAM/LFSR address width
- DATA_W, 32, RAM/LFSR data width
- NUM_OPS, 1023, strobes per phase, legal range 1..2^ADDR_W-1
- RST_CYC, 2, cycles lfsr_rstn is held low per LFSR reset, legal range >=1
- RD_LAT, 1, RAM read latency in cycles, legal range 1..3

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a test when not busy
- abort  in  1  level; terminates a running test
- busy  out  1  high from accepted start until DONE or IDLE
- done  out  1  high in DONE; held until next accepted start or rst
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  16  mismatch count, saturates at 16'hFFFF
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
- lfsr_rstn  out  1  LFSR reset, active-low
- lfsr_en_addr  out  1  strobe to address LFSR
- lfsr_en_data  out  1  strobe to data LFSR
- lfsr_addr  in  ADDR_W  LFSR address output
- lfsr_data  in  DATA_W  LFSR data output
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, RD_LAT cycles after mem_en & ~mem_we

Behaviour:
- All outputs registered.
- Reset values (rst=1):
  - busy=0, done=0, pass=0, err_count=0, first_err_addr=0
  - lfsr_rstn=0 (LFSR held in reset while rst=1)
  - lfsr_en_addr=0, lfsr_en_data=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
- LFSR strobe protocol:
  - The LFSR captures its output on the rising edge of en and advances on the falling edge.
  - Both strobes go high together for exactly 1 cycle (S_HI), then low for at least 1 cycle (S_LO).
  - lfsr_addr/lfsr_data are sampled only in the cycle after S_LO.
  - Strobes are never high while lfsr_rstn=0.
- States:
  - IDLE: lfsr_rstn=1. On start: clear err_count/first_err_addr/done/pass, set busy=1, phase=WR, go LRST.
  - LRST: lfsr_rstn=0 for RST_CYC cycles, then lfsr_rstn=1 for 1 cycle, op_cnt=0, go S_HI.
  - S_HI: strobes=1, go S_LO.
  - S_LO: strobes=0, go ACC.
  - ACC, write phase:
    - mem_en=1, mem_we=1, mem_addr=lfsr_addr, mem_wdata=lfsr_data for 1 cycle.
    - op_cnt++. If op_cnt reaches NUM_OPS: phase=RD, go LRST. Else go S_HI.
  - ACC, read phase:
    - mem_en=1, mem_we=0, mem_addr=lfsr_addr for 1 cycle.
    - Latch exp_data=lfsr_data and exp_addr=lfsr_addr; go RD_WAIT.
  - RD_WAIT: wait RD_LAT cycles total from ACC, then go CMP.
  - CMP:
    - On mem_rdata != exp_data: err_count++ (saturating). If this is the first error, first_err_addr=exp_addr.
    - op_cnt++. If op_cnt reaches NUM_OPS go DONE, else S_HI.
  - DONE: busy=0, done=1, pass=(err_count==0). On start: restart as from IDLE.
- Timing per op: write = 3 cycles; read = 3+RD_LAT+1 cycles. With RD_LAT=1, total test cycles = (RST_CYC+1)*2 + 3*NUM_OPS + 5*NUM_OPS.
- mem_en/mem_we are 0 in every state other than ACC.
- Boundary conditions:
  - start while busy: ignored.
  - start and abort in the same cycle in IDLE/DONE: abort wins; stay or return to IDLE with done=0.
  - abort while busy: next cycle go IDLE with busy=0, done=0, strobes=0, mem_en=0; counters hold their values.
  - rst mid-test: full reset next edge. No RAM write occurs in the rst cycle.
  - err_count at 16'hFFFF stays at 16'hFFFF.
  - op_cnt width = ADDR_W; NUM_OPS=1 is legal.

Test Plan:
- Reset, start, NUM_OPS=2, RD_LAT=1, RST_CYC=2, ideal RAM:
  - Writes: (0x3FF, 0xFFFFFFFF) then (0x3F7, 0xFFBFFFF9).
  - done rises 22 cycles after start accepted; pass=1, err_count=0.
- Full run NUM_OPS=1023: 1023 distinct nonzero write addresses (address 0 never written); pass=1; read sequence equals write sequence.
- RAM model flips bit 0 on reads of 0x3F7, NUM_OPS=2: err_count=1, first_err_addr=0x3F7, pass=0.
- Abort asserted during the 5th S_HI: next cycle busy=0, done=0, mem_en=0, strobes=0. A following start yields a clean pass.
- rst during a write-phase ACC: no further mem_en; all outputs at reset values; lfsr_rstn=0 while rst=1.
- start pulsed while busy: no restart, cycle count unchanged. Stuck-at-0 RAM with NUM_OPS=1023: err_count=1023, first_err_addr=0x3FF.
